// File: rtl/mvm_noc_pkg.sv
// Shared definitions for MVM NoC injectors: widths, TUSER layout, op codes,
// the 32-bit MVM instruction word and the sequencer state encoding.
package mvm_noc_pkg;
    localparam int DATAW   = 512;
    localparam int DESTW   = 12;
    localparam int USERW   = 75;
    localparam int IDW     = 1;
    localparam int RF_ROWS = 64;
    localparam int TILESW  = 6;

    localparam logic [1:0] OP_INST = 2'b00;
    localparam logic [1:0] OP_VEC  = 2'b10;
    localparam logic [1:0] OP_WGT  = 2'b11;

    localparam int TU_RF_LSB   = 0;
    localparam int TU_OP_LSB   = 9;
    localparam int TU_ROW_BASE = 11;

    localparam int INST_RDC       = 0;
    localparam int INST_ACM_EN    = 1;
    localparam int INST_RLS       = 2;
    localparam int INST_LST       = 3;
    localparam int INST_ACCUM_LSB = 4;
    localparam int INST_RF_LSB    = 13;
    localparam int INST_RLSD_LSB  = 22;
    localparam int INST_RLS_OP    = 31;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic       rls_op;
        logic [8:0] rls_dest;
        logic [8:0] rf_addr;
        logic [8:0] accum_addr;
        logic       lst;
        logic       rls;
        logic       acm_en;
        logic       rdc;
    } mvm_inst_t;

    typedef enum logic [2:0] {
        S_IDLE, S_WGT, S_VEC_CAP, S_VEC, S_INST, S_DONE
    } seq_state_t;
endpackage

// File: rtl/mvm_noc_sequencer_if.sv
// Host-side bundle of the sequencer: command, weight/vector streams and the
// NoC injection port. master = host/DMA side, slave = sequencer side.
interface mvm_noc_sequencer_if #(
    parameter int DATAW  = mvm_noc_pkg::DATAW,
    parameter int DESTW  = mvm_noc_pkg::DESTW,
    parameter int USERW  = mvm_noc_pkg::USERW,
    parameter int IDW    = mvm_noc_pkg::IDW,
    parameter int TILESW = mvm_noc_pkg::TILESW
);
    logic              CMD_VALID, CMD_READY;
    logic [DESTW-1:0]  CMD_START_DEST;
    logic [TILESW-1:0] CMD_NUM_TILES;
    logic [8:0]        CMD_RF_ADDR, CMD_ACCUM_ADDR, CMD_RLS_DEST;
    logic              CMD_LOAD_WGT, CMD_ACM_EN, CMD_RLS, CMD_LST, CMD_RLS_OP;
    logic              WGT_VALID, WGT_READY;
    logic [DATAW-1:0]  WGT_DATA;
    logic              VEC_VALID, VEC_READY;
    logic [DATAW-1:0]  VEC_DATA;
    logic              AXIS_M_TVALID, AXIS_M_TREADY, AXIS_M_TLAST;
    logic [DATAW-1:0]  AXIS_M_TDATA;
    logic [USERW-1:0]  AXIS_M_TUSER;
    logic [DESTW-1:0]  AXIS_M_TDEST;
    logic [IDW-1:0]    AXIS_M_TID;

    modport master (
        output CMD_VALID, CMD_START_DEST, CMD_NUM_TILES, CMD_RF_ADDR, CMD_ACCUM_ADDR,
               CMD_RLS_DEST, CMD_LOAD_WGT, CMD_ACM_EN, CMD_RLS, CMD_LST, CMD_RLS_OP,
               WGT_VALID, WGT_DATA, VEC_VALID, VEC_DATA, AXIS_M_TREADY,
        input  CMD_READY, WGT_READY, VEC_READY, AXIS_M_TVALID, AXIS_M_TDATA,
               AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID, AXIS_M_TLAST
    );
    modport slave (
        input  CMD_VALID, CMD_START_DEST, CMD_NUM_TILES, CMD_RF_ADDR, CMD_ACCUM_ADDR,
               CMD_RLS_DEST, CMD_LOAD_WGT, CMD_ACM_EN, CMD_RLS, CMD_LST, CMD_RLS_OP,
               WGT_VALID, WGT_DATA, VEC_VALID, VEC_DATA, AXIS_M_TREADY,
        output CMD_READY, WGT_READY, VEC_READY, AXIS_M_TVALID, AXIS_M_TDATA,
               AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID, AXIS_M_TLAST
    );
endinterface

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: reloads when empty or when the held
// beat fires, sustaining one beat per cycle and holding the payload while stalled.
module axis_out_reg #(
    parameter int DATAW = 512,
    parameter int DESTW = 12,
    parameter int USERW = 75,
    parameter int IDW   = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DATAW-1:0] in_data_i,
    input  logic [USERW-1:0] in_user_i,
    input  logic [DESTW-1:0] in_dest_i,
    input  logic [IDW-1:0]   in_id_i,
    input  logic             in_last_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic [DATAW-1:0] m_tdata_o,
    output logic [USERW-1:0] m_tuser_o,
    output logic [DESTW-1:0] m_tdest_o,
    output logic [IDW-1:0]   m_tid_o,
    output logic             m_tlast_o
);
    logic             valid_q, last_q;
    logic [DATAW-1:0] data_q;
    logic [USERW-1:0] user_q;
    logic [DESTW-1:0] dest_q;
    logic [IDW-1:0]   id_q;

    assign in_ready_o = ~valid_q | m_tready_i;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            dest_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
                user_q <= in_user_i;
                dest_q <= in_dest_i;
                id_q   <= in_id_i;
                last_q <= in_last_i;
            end
        end
    end

    assign m_tvalid_o = valid_q;
    assign m_tdata_o  = data_q;
    assign m_tuser_o  = user_q;
    assign m_tdest_o  = dest_q;
    assign m_tid_o    = id_q;
    assign m_tlast_o  = last_q;
endmodule

// File: rtl/mvm_noc_sequencer.sv
// Builds the weight-write, vector-load and instruction packets for a contiguous
// range of MVM tiles from one layer command, in that order.
module mvm_noc_sequencer #(
    parameter int DATAW   = mvm_noc_pkg::DATAW,
    parameter int DESTW   = mvm_noc_pkg::DESTW,
    parameter int USERW   = mvm_noc_pkg::USERW,
    parameter int IDW     = mvm_noc_pkg::IDW,
    parameter int RF_ROWS = mvm_noc_pkg::RF_ROWS,
    parameter int TILESW  = mvm_noc_pkg::TILESW
) (
    input  logic                CLK,
    input  logic                RST,
    mvm_noc_sequencer_if.slave  bus,
    output logic                BUSY,
    output logic                DONE
);
    import mvm_noc_pkg::*;

    localparam int ROWW = $clog2(RF_ROWS);
    localparam int SHW  = $clog2(USERW);

    seq_state_t        state_q;
    logic [DESTW-1:0]  start_dest_q;
    logic [TILESW-1:0] num_tiles_q, t_q;
    logic [ROWW-1:0]   r_q;
    logic [8:0]        rf_addr_q, accum_addr_q, rls_dest_q;
    logic              acm_en_q, rls_q, lst_q, rls_op_q;
    logic [DATAW-1:0]  vec_q;

    logic              beat_valid, beat_ready, beat_fire, last_tile, last_row;
    logic [DATAW-1:0]  beat_data;
    logic [USERW-1:0]  beat_user;
    mvm_inst_t         inst_word;

    always_comb begin
        last_tile = (t_q == num_tiles_q - TILESW'(1));
        last_row  = (r_q == ROWW'(RF_ROWS - 1));
        inst_word            = '0;
        inst_word.acm_en     = acm_en_q;
        inst_word.rls        = rls_q;
        // A releasing layer only marks the final tile as last.
        inst_word.lst        = lst_q & (last_tile | ~rls_q);
        inst_word.accum_addr = accum_addr_q;
        inst_word.rf_addr    = rf_addr_q;
        inst_word.rls_dest   = rls_dest_q;
        inst_word.rls_op     = rls_op_q;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_user  = '0;
        unique case (state_q)
            S_WGT: begin
                beat_valid = bus.WGT_VALID;
                beat_data  = bus.WGT_DATA;
                beat_user  = USERW'(1) << (SHW'(TU_ROW_BASE) + SHW'(r_q));
                beat_user[TU_RF_LSB +: 9] = rf_addr_q;
                beat_user[TU_OP_LSB +: 2] = OP_WGT;
            end
            S_VEC: begin
                beat_valid = 1'b1;
                beat_data  = vec_q;
                beat_user[TU_OP_LSB +: 2] = OP_VEC;
            end
            S_INST: begin
                beat_valid = (t_q != num_tiles_q);
                beat_data  = DATAW'(inst_word);
            end
            default: ;
        endcase
    end

    assign beat_fire     = beat_valid & beat_ready;
    assign bus.CMD_READY = (state_q == S_IDLE);
    assign bus.WGT_READY = (state_q == S_WGT) & beat_ready;
    assign bus.VEC_READY = (state_q == S_VEC_CAP);
    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            r_q          <= '0;
            start_dest_q <= '0;
            num_tiles_q  <= '0;
            rf_addr_q    <= '0;
            accum_addr_q <= '0;
            rls_dest_q   <= '0;
            acm_en_q     <= 1'b0;
            rls_q        <= 1'b0;
            lst_q        <= 1'b0;
            rls_op_q     <= 1'b0;
            vec_q        <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.CMD_VALID) begin
                    start_dest_q <= bus.CMD_START_DEST;
                    num_tiles_q  <= bus.CMD_NUM_TILES;
                    rf_addr_q    <= bus.CMD_RF_ADDR;
                    accum_addr_q <= bus.CMD_ACCUM_ADDR;
                    rls_dest_q   <= bus.CMD_RLS_DEST;
                    acm_en_q     <= bus.CMD_ACM_EN;
                    rls_q        <= bus.CMD_RLS;
                    lst_q        <= bus.CMD_LST;
                    rls_op_q     <= bus.CMD_RLS_OP;
                    t_q          <= '0;
                    r_q          <= '0;
                    if (bus.CMD_NUM_TILES == '0)
                        state_q <= S_DONE;
                    else if (bus.CMD_LOAD_WGT)
                        state_q <= S_WGT;
                    else
                        state_q <= S_VEC_CAP;
                end
                S_WGT: if (beat_fire) begin
                    r_q <= last_row ? '0 : r_q + ROWW'(1);
                    if (last_row) begin
                        t_q <= last_tile ? '0 : t_q + TILESW'(1);
                        if (last_tile)
                            state_q <= S_VEC_CAP;
                    end
                end
                S_VEC_CAP: if (bus.VEC_VALID) begin
                    vec_q   <= bus.VEC_DATA;
                    t_q     <= '0;
                    state_q <= S_VEC;
                end
                S_VEC: if (beat_fire) begin
                    t_q <= last_tile ? '0 : t_q + TILESW'(1);
                    if (last_tile)
                        state_q <= S_INST;
                end
                S_INST: begin
                    // Once every instruction is queued, wait for the final beat to leave.
                    if (beat_fire)
                        t_q <= t_q + TILESW'(1);
                    else if (t_q == num_tiles_q && bus.AXIS_M_TVALID && bus.AXIS_M_TREADY)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .DATAW(DATAW), .DESTW(DESTW), .USERW(USERW), .IDW(IDW)
    ) u_out (
        .clk        (CLK),
        .srst       (RST),
        .in_valid_i (beat_valid),
        .in_ready_o (beat_ready),
        .in_data_i  (beat_data),
        .in_user_i  (beat_user),
        .in_dest_i  (start_dest_q + DESTW'(t_q)),
        .in_id_i    ('0),
        .in_last_i  (1'b1),
        .m_tvalid_o (bus.AXIS_M_TVALID),
        .m_tready_i (bus.AXIS_M_TREADY),
        .m_tdata_o  (bus.AXIS_M_TDATA),
        .m_tuser_o  (bus.AXIS_M_TUSER),
        .m_tdest_o  (bus.AXIS_M_TDEST),
        .m_tid_o    (bus.AXIS_M_TID),
        .m_tlast_o  (bus.AXIS_M_TLAST)
    );
endmodule

// File: tb/tb_mvm_noc_sequencer.sv
// Scoreboard bench for mvm_noc_sequencer: expected packets are derived from each
// command and queued; a negedge monitor pops and compares every fired beat.
module tb_mvm_noc_sequencer;
    typedef struct {
        logic [511:0] data;
        logic [74:0]  user;
        logic [11:0]  dest;
    } beat_t;

    typedef struct {
        logic [11:0] start;
        int          tiles;
        logic [8:0]  rf, accum, rls_dest;
        bit          load_wgt, acm, rls, lst, rls_op;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done;

    mvm_noc_sequencer_if bus();

    mvm_noc_sequencer dut (
        .CLK  (clk),
        .RST  (rst),
        .bus  (bus),
        .BUSY (busy),
        .DONE (done)
    );

    int total = 0, bad = 0;
    int cyc = 0, fire_cnt = 0, done_cnt = 0, done_cyc = 0, last_fire_cyc = 0;
    bit rand_ready = 1'b0;
    beat_t sb[$];
    logic [511:0] wgt_q[$];
    logic [511:0] vec_val;

    bit           held = 1'b0, done_prev = 1'b0;
    logic [511:0] h_data;
    logic [86:0]  h_ud;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        bus.AXIS_M_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Monitor: stall stability, scoreboard pops, DONE pulse bookkeeping.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rst) begin
            held      = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (held) begin
                chki("stall_valid", int'(bus.AXIS_M_TVALID), 1);
                chkw("stall_data", bus.AXIS_M_TDATA, h_data);
                chkw("stall_user_dest", 512'({bus.AXIS_M_TDEST, bus.AXIS_M_TUSER}), 512'(h_ud));
            end
            held   = bus.AXIS_M_TVALID && !bus.AXIS_M_TREADY;
            h_data = bus.AXIS_M_TDATA;
            h_ud   = {bus.AXIS_M_TDEST, bus.AXIS_M_TUSER};
            if (bus.AXIS_M_TVALID && bus.AXIS_M_TREADY) begin
                fire_cnt++;
                last_fire_cyc = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: unexpected beat tdest=%0h tuser=%0h", bus.AXIS_M_TDEST, bus.AXIS_M_TUSER);
                end else begin
                    e = sb.pop_front();
                    chkw("tdata", bus.AXIS_M_TDATA, e.data);
                    chkw("tuser", 512'(bus.AXIS_M_TUSER), 512'(e.user));
                    chki("tdest", int'(bus.AXIS_M_TDEST), int'(e.dest));
                    chki("tlast", int'(bus.AXIS_M_TLAST), 1);
                    chki("tid", int'(bus.AXIS_M_TID), 0);
                end
            end
            if (done_prev) chki("done_pulse", int'(done), 0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            done_prev = done;
        end
    end

    task automatic feed_wgt(input int n, input int stall_at, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            if (i == stall_at) begin
                bus.WGT_VALID = 1'b0;
                repeat (10) @(posedge clk);
                #1;
            end
            bus.WGT_VALID = 1'b1;
            bus.WGT_DATA  = wgt_q[i];
            forever begin
                @(negedge clk);
                if (bus.WGT_READY) break;
                guard++;
                if (guard > 500) break;
            end
            if (guard > 500) begin
                chki("wgt_ready_timeout", guard, 0);
                bus.WGT_VALID = 1'b0;
                ok = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.WGT_VALID = 1'b0;
    endtask

    task automatic run_cmd(input cmd_t c, input int stall_at, input int rst_at);
        int    f0 = fire_cnt, d0 = done_cnt, n = 0, guard = 0;
        bit    ok = 1'b1;
        beat_t e;
        logic [31:0] w;
        bit    lst_t;
        wgt_q.delete();
        if (c.load_wgt) begin
            for (int t = 0; t < c.tiles; t++) begin
                for (int r = 0; r < 64; r++) begin
                    e.data = rnd512();
                    wgt_q.push_back(e.data);
                    e.user = (75'(1) << (11 + r)) | (75'(3) << 9) | 75'(c.rf);
                    e.dest = 12'((int'(c.start) + t) % 4096);
                    sb.push_back(e);
                    n++;
                end
            end
        end
        vec_val = rnd512();
        for (int t = 0; t < c.tiles; t++) begin
            e.data = vec_val;
            e.user = 75'(2) << 9;
            e.dest = 12'((int'(c.start) + t) % 4096);
            sb.push_back(e);
            n++;
        end
        for (int t = 0; t < c.tiles; t++) begin
            lst_t = c.lst && ((t == c.tiles - 1) || !c.rls);
            w = (32'(c.rls_op) << 31) | (32'(c.rls_dest) << 22) | (32'(c.rf) << 13) |
                (32'(c.accum) << 4) | (32'(lst_t) << 3) | (32'(c.rls) << 2) | (32'(c.acm) << 1);
            e.data = 512'(w);
            e.user = '0;
            e.dest = 12'((int'(c.start) + t) % 4096);
            sb.push_back(e);
            n++;
        end

        bus.CMD_START_DEST = c.start;
        bus.CMD_NUM_TILES  = 6'(c.tiles);
        bus.CMD_RF_ADDR    = c.rf;
        bus.CMD_ACCUM_ADDR = c.accum;
        bus.CMD_RLS_DEST   = c.rls_dest;
        bus.CMD_LOAD_WGT   = c.load_wgt;
        bus.CMD_ACM_EN     = c.acm;
        bus.CMD_RLS        = c.rls;
        bus.CMD_LST        = c.lst;
        bus.CMD_RLS_OP     = c.rls_op;
        bus.CMD_VALID      = 1'b1;
        @(negedge clk);
        chki("cmd_ready", int'(bus.CMD_READY), 1);
        @(posedge clk);
        #1;
        bus.CMD_VALID = 1'b0;

        if (rst_at >= 0) begin
            feed_wgt(rst_at, -1, ok);
            rst = 1'b1;
            @(posedge clk);
            #1;
            sb.delete();
            rst = 1'b0;
            @(negedge clk);
            chki("rst_tvalid", int'(bus.AXIS_M_TVALID), 0);
            chki("rst_busy", int'(busy), 0);
            chki("rst_cmd_ready", int'(bus.CMD_READY), 1);
            repeat (5) @(posedge clk);
            #1;
            chki("rst_no_done", done_cnt - d0, 0);
            return;
        end

        if (c.tiles != 0) begin
            if (c.load_wgt) feed_wgt(c.tiles * 64, stall_at, ok);
            if (ok) begin
                bus.VEC_VALID = 1'b1;
                bus.VEC_DATA  = vec_val;
                guard = 0;
                forever begin
                    @(negedge clk);
                    if (bus.VEC_READY || guard > 500) break;
                    guard++;
                end
                if (guard > 500) chki("vec_ready_timeout", guard, 0);
                @(posedge clk);
                #1;
                bus.VEC_VALID = 1'b0;
            end
        end

        guard = 0;
        while (done_cnt == d0 && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chki("done_count", done_cnt - d0, 1);
        chki("beat_count", fire_cnt - f0, n);
        chki("sb_empty", sb.size(), 0);
        if (n > 0) chki("done_latency", done_cyc - last_fire_cyc, 1);
        sb.delete();
    endtask

    initial begin
        cmd_t c1, c;
        #500000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c1, c;
        bus.CMD_VALID = 1'b0;      bus.CMD_START_DEST = '0; bus.CMD_NUM_TILES = '0;
        bus.CMD_RF_ADDR = '0;      bus.CMD_ACCUM_ADDR = '0; bus.CMD_RLS_DEST = '0;
        bus.CMD_LOAD_WGT = 1'b0;   bus.CMD_ACM_EN = 1'b0;   bus.CMD_RLS = 1'b0;
        bus.CMD_LST = 1'b0;        bus.CMD_RLS_OP = 1'b0;
        bus.WGT_VALID = 1'b0;      bus.WGT_DATA = '0;
        bus.VEC_VALID = 1'b0;      bus.VEC_DATA = '0;
        bus.AXIS_M_TREADY = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chki("reset_cmd_ready", int'(bus.CMD_READY), 1);
        chki("reset_tvalid", int'(bus.AXIS_M_TVALID), 0);
        chki("reset_busy", int'(busy), 0);
        chki("reset_done", int'(done), 0);
        chki("reset_wgt_ready", int'(bus.WGT_READY), 0);
        chki("reset_vec_ready", int'(bus.VEC_READY), 0);
        chkw("reset_tdata", bus.AXIS_M_TDATA, '0);

        // A vector offered while idle must be ignored.
        @(posedge clk);
        #1;
        bus.VEC_VALID = 1'b1;
        bus.VEC_DATA  = rnd512();
        @(negedge clk);
        chki("vec_ready_idle", int'(bus.VEC_READY), 0);
        @(posedge clk);
        #1;
        bus.VEC_VALID = 1'b0;

        c1 = '{12'h001, 2, 9'd1, 9'd0, 9'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        run_cmd(c1, -1, -1);

        c = c1; c.load_wgt = 1'b0; c.rls = 1'b1;
        run_cmd(c, -1, -1);

        rand_ready = 1'b1;
        run_cmd(c1, -1, -1);
        rand_ready = 1'b0;

        c = c1; c.tiles = 0;
        run_cmd(c, -1, -1);

        c = c1; c.start = 12'hFFF;
        run_cmd(c, -1, -1);

        run_cmd(c1, -1, 30);
        run_cmd(c1, -1, -1);
        run_cmd(c1, 40, -1);

        rand_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c.start    = 12'($urandom());
            c.tiles    = int'($urandom_range(1, 3));
            c.rf       = 9'($urandom());
            c.accum    = 9'($urandom());
            c.rls_dest = 9'($urandom());
            c.load_wgt = 1'($urandom());
            c.acm      = 1'($urandom());
            c.rls      = 1'($urandom());
            c.lst      = 1'($urandom());
            c.rls_op   = 1'($urandom());
            run_cmd(c, (k == 1) ? 17 : -1, -1);
        end
        rand_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
